// File: rtl/timer_multi_pkg.sv
// ---------------------------------------------------------------------------
// timer_multi_pkg
// Shared constants for the multi-channel Wishbone timer: per-channel register
// offsets (selected by wb_addr[1:0]), CSR bit positions and mode encoding.
// ---------------------------------------------------------------------------
package timer_multi_pkg;

    // Register offsets inside one channel's 4-word window
    localparam logic [1:0] REG_CSR     = 2'd0;
    localparam logic [1:0] REG_LOAD    = 2'd1;
    localparam logic [1:0] REG_RELOAD  = 2'd2;
    localparam logic [1:0] REG_COUNTER = 2'd3;

    // CSR bit positions
    localparam int CSR_EN    = 0;
    localparam int CSR_MODE  = 1;
    localparam int CSR_EV    = 2;
    localparam int CSR_EV_EN = 3;
    localparam int CSR_ST    = 4;
    localparam int CSR_W     = 5;

    // CSR.mode encoding
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_multi_ch.sv
// ---------------------------------------------------------------------------
// timer_multi_ch
// One timer channel: CSR/LOAD/RELOAD registers, the down-counter and the
// sticky event flag.
//
// Build option: TIMER_MULTI_WB_IRQ_EN -- when defined the ev_en mask bit
// exists and irq_req = ev & ev_en; otherwise ev_en reads 0 and irq_req is 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tick                one-cycle prescaler pulse
//   we_csr/we_load/we_reload  register write strobes (one cycle)
//   wdata               write data (bits above CNT_W are discarded)
//   csr_val             CSR readback {st, ev_en, ev, mode, en}
//   load_val, reload_val, cnt_val  register / counter readback
//   irq_req             ev & ev_en
// ---------------------------------------------------------------------------
module timer_multi_ch
    import timer_multi_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              we_csr,
    input  logic              we_load,
    input  logic              we_reload,
    input  logic [31:0]       wdata,
    output logic [CSR_W-1:0]  csr_val,
    output logic [CNT_W-1:0]  load_val,
    output logic [CNT_W-1:0]  reload_val,
    output logic [CNT_W-1:0]  cnt_val,
    output logic              irq_req
);

    logic             en;
    logic             mode;
    logic             ev;
    logic             ev_en;
    logic [CNT_W-1:0] load_r;
    logic [CNT_W-1:0] reload_r;
    logic [CNT_W-1:0] cnt;

    logic cnt_zero;
    logic zero_ev;
    logic start;
    logic en_after;

    assign cnt_zero = (cnt == '0);
    assign zero_ev  = tick & en & cnt_zero;
    // en 0->1 write: load LOAD regardless of where the prescaler is
    assign start    = we_csr & wdata[CSR_EN] & ~en;
    // value en will hold after this edge if only the bus acted on it
    assign en_after = we_csr ? wdata[CSR_EN] : en;

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            mode     <= MODE_PERIODIC;
            ev       <= 1'b0;
            load_r   <= '0;
            reload_r <= '0;
            cnt      <= '0;
        end else begin
            if (we_load)   load_r   <= wdata[CNT_W-1:0];
            if (we_reload) reload_r <= wdata[CNT_W-1:0];
            if (we_csr) begin
                en   <= wdata[CSR_EN];
                mode <= wdata[CSR_MODE];
            end

            // A new event beats a simultaneous write-1 clear
            ev <= zero_ev | (ev & ~(we_csr & wdata[CSR_EV]));

            if (start) begin
                cnt <= load_r;
            end else if (tick && en) begin
                if (!cnt_zero) begin
                    cnt <= cnt - CNT_W'(1);
                end else if (en_after) begin
                    // reload_r is the pre-write value here, so a RELOAD write
                    // landing on the event edge only affects the next period.
                    if (mode == MODE_PERIODIC) cnt <= reload_r;
                    // one-shot stop; a concurrent CSR write keeps its own en
                    else if (!we_csr) en <= 1'b0;
                end
            end
        end
    end

`ifdef TIMER_MULTI_WB_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst)         ev_en <= 1'b0;
        else if (we_csr) ev_en <= wdata[CSR_EV_EN];
    end
    assign irq_req = ev & ev_en;
`else
    assign ev_en   = 1'b0;
    assign irq_req = 1'b0;
`endif

    // Not every wdata bit is stored (width, RO bits, build option)
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    always_comb begin
        csr_val            = '0;
        csr_val[CSR_EN]    = en;
        csr_val[CSR_MODE]  = mode;
        csr_val[CSR_EV]    = ev;
        csr_val[CSR_EV_EN] = ev_en;
        csr_val[CSR_ST]    = ~cnt_zero;
    end

    assign load_val   = load_r;
    assign reload_val = reload_r;
    assign cnt_val    = cnt;

endmodule

// File: rtl/timer_multi_wb.sv
// ---------------------------------------------------------------------------
// timer_multi_wb
// N_CH-channel microsecond timer on Wishbone. One free-running prescaler
// produces a tick every PRESCALE clocks; each channel is a timer_multi_ch.
//
// Build option: TIMER_MULTI_WB_IRQ_EN -- defined: irq is the registered OR of
// every channel's ev & ev_en; undefined: irq is tied to 0.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wb_addr      [1:0] register select, upper bits channel select
//   wb_rdata     registered read data, non-zero only in the ack cycle
//   wb_wdata     write data
//   wb_we        write enable
//   wb_cyc       cycle strobe
//   wb_ack       registered acknowledge, one cycle per access
//   irq          level interrupt
// ---------------------------------------------------------------------------
module timer_multi_wb
    import timer_multi_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int PRESCALE = 24,
    parameter int CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(N_CH)+1:0] wb_addr,
    output logic [31:0]             wb_rdata,
    input  logic [31:0]             wb_wdata,
    input  logic                    wb_we,
    input  logic                    wb_cyc,
    output logic                    wb_ack,
    output logic                    irq
);

    localparam int AW = $clog2(N_CH) + 2;
    localparam int PW = $clog2(PRESCALE);

    // Prescaler: free-running, first tick PRESCALE cycles after reset
    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + PW'(1);
    end

    // Address decode; writes commit on the edge that ends the ack cycle
    logic [1:0]    reg_sel;
    logic [AW-1:0] ch_sel;
    logic          wr_strobe;

    assign reg_sel   = wb_addr[1:0];
    assign ch_sel    = wb_addr >> 2;
    assign wr_strobe = wb_cyc & wb_we & wb_ack;

    logic [CSR_W-1:0] csr_v    [N_CH];
    logic [CNT_W-1:0] load_v   [N_CH];
    logic [CNT_W-1:0] reload_v [N_CH];
    logic [CNT_W-1:0] cnt_v    [N_CH];
    logic [N_CH-1:0]  irq_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_strobe & (ch_sel == AW'(i));

        timer_multi_ch #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .we_csr     (ch_wr && (reg_sel == REG_CSR)),
            .we_load    (ch_wr && (reg_sel == REG_LOAD)),
            .we_reload  (ch_wr && (reg_sel == REG_RELOAD)),
            .wdata      (wb_wdata),
            .csr_val    (csr_v[i]),
            .load_val   (load_v[i]),
            .reload_val (reload_v[i]),
            .cnt_val    (cnt_v[i]),
            .irq_req    (irq_v[i])
        );
    end

    // Read mux; channels beyond N_CH-1 fall through to 0
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == AW'(i)) begin
                case (reg_sel)
                    REG_CSR:     rd_mux = 32'(csr_v[i]);
                    REG_LOAD:    rd_mux = 32'(load_v[i]);
                    REG_RELOAD:  rd_mux = 32'(reload_v[i]);
                    REG_COUNTER: rd_mux = 32'(cnt_v[i]);
                    default:     rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
        end else begin
            wb_ack   <= wb_cyc & ~wb_ack;
            wb_rdata <= (wb_cyc & ~wb_ack & ~wb_we) ? rd_mux : '0;
        end
    end

`ifdef TIMER_MULTI_WB_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= |irq_v;
    end
`else
    assign irq = 1'b0;
    logic unused_irq;
    assign unused_irq = |irq_v;
`endif

endmodule

// File: tb/tb_timer_multi_wb.sv
// ---------------------------------------------------------------------------
// tb_timer_multi_wb
// Self-checking bench for timer_multi_wb (N_CH=3, PRESCALE=24, CNT_W=16).
// Expected irq / CSR[3] values follow the TIMER_MULTI_WB_IRQ_EN build option.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_multi_wb;

    localparam int N_CH     = 3;
    localparam int PRESCALE = 24;
    localparam int CNT_W    = 16;
`ifdef TIMER_MULTI_WB_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [31:0] EVB = IRQ_EN ? 32'h8 : 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [31:0] wb_rdata;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;   // clock edges since reset release: tick edges are multiples of PRESCALE

    timer_multi_wb #(.N_CH(N_CH), .PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_addr  (wb_addr),
        .wb_rdata (wb_rdata),
        .wb_wdata (wb_wdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= rst ? 0 : ecnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus access; returns the data seen in the ack cycle
    task automatic xfer(input logic [3:0] a, input logic we, input logic [31:0] d,
                        output logic [31:0] rd);
        @(negedge clk);
        wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
        @(negedge clk);
        check("ack_rise", {31'b0, wb_ack}, 32'h1);
        rd = wb_rdata;
        @(negedge clk);
        check("ack_one_cycle", {31'b0, wb_ack}, 32'h0);
        if (!we) check("rdata_idle", wb_rdata, 32'h0);
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] v;
        xfer(a, 1'b1, d, v);
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        xfer(a, 1'b0, 32'h0, v);
        check(name, v, exp);
    endtask

    task automatic irq_chk(input logic exp, input string name);
        @(negedge clk);
        @(negedge clk);
        check(name, {31'b0, irq}, {31'b0, exp});
    endtask

    // Returns just after the n-th tick edge from now
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do begin
                @(posedge clk); #1;
            end while (ecnt % PRESCALE != 0);
        end
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // {addr, we, wdata, expected read}
        vecs[0]  = '{4'h1, 1'b1, 32'h0001_2345, 32'h0};     // ch0 LOAD, upper bits dropped
        vecs[1]  = '{4'h1, 1'b0, 32'h0,         32'h2345};
        vecs[2]  = '{4'h2, 1'b1, 32'hFFFF_FFFF, 32'h0};     // ch0 RELOAD
        vecs[3]  = '{4'h2, 1'b0, 32'h0,         32'hFFFF};
        vecs[4]  = '{4'h3, 1'b1, 32'h0000_0055, 32'h0};     // COUNTER is read-only
        vecs[5]  = '{4'h3, 1'b0, 32'h0,         32'h0};
        vecs[6]  = '{4'h4, 1'b1, 32'hFFFF_FFFA, 32'h0};     // ch1 CSR, en=0
        vecs[7]  = '{4'h4, 1'b0, 32'h0,         32'h2 | EVB};
        vecs[8]  = '{4'h9, 1'b1, 32'h0000_ABCD, 32'h0};     // ch2 LOAD
        vecs[9]  = '{4'h9, 1'b0, 32'h0,         32'hABCD};
        vecs[10] = '{4'h1, 1'b0, 32'h0,         32'h2345};
        vecs[11] = '{4'hD, 1'b1, 32'h0000_1111, 32'h0};     // channel 3 does not exist
        vecs[12] = '{4'hD, 1'b0, 32'h0,         32'h0};
        vecs[13] = '{4'h5, 1'b0, 32'h0,         32'h0};     // ch1 LOAD untouched
        vecs[14] = '{4'h4, 1'b1, 32'h0,         32'h0};
        vecs[15] = '{4'h4, 1'b0, 32'h0,         32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_irq", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 16; a++) rd_chk(a[3:0], 32'h0, $sformatf("reset_reg%0d", a));

        // Register access table
        for (int i = 0; i < 16; i++) begin
            logic [31:0] v;
            xfer(vecs[i].addr, vecs[i].we, vecs[i].wdata, v);
            if (!vecs[i].we) check($sformatf("vec%0d", i), v, vecs[i].exp);
        end

        // Channel 0 periodic: LOAD=3, RELOAD=9
        wait_ticks(1);
        wr(4'h1, 32'd3);
        wr(4'h2, 32'd9);
        wr(4'h0, 32'h9);
        wait_ticks(3);
        rd_chk(4'h3, 32'd0, "p_cnt_t3");
        rd_chk(4'h0, 32'h1 | EVB, "p_csr_t3");
        check("p_irq_t3", {31'b0, irq}, 32'h0);
        wait_ticks(1);
        irq_chk(IRQ_EN, "p_irq_t4");
        rd_chk(4'h0, 32'h15 | EVB, "p_csr_t4");
        rd_chk(4'h3, 32'd9, "p_cnt_t4");
        wait_ticks(9);
        rd_chk(4'h3, 32'd0, "p_cnt_t13");
        rd_chk(4'h0, 32'h5 | EVB, "p_csr_t13");
        wait_ticks(1);
        rd_chk(4'h3, 32'd9, "p_cnt_t14");
        wr(4'h0, 32'hD);
        rd_chk(4'h0, 32'h11 | EVB, "p_csr_clr");
        irq_chk(1'b0, "p_irq_clr");
        wr(4'h0, 32'h4);

        // Channel 2 one-shot: LOAD=5, masked
        wait_ticks(1);
        wr(4'h9, 32'd5);
        wr(4'h8, 32'h3);
        wait_ticks(5);
        rd_chk(4'hB, 32'd0, "os_cnt_t5");
        rd_chk(4'h8, 32'h3, "os_csr_t5");
        wait_ticks(1);
        rd_chk(4'h8, 32'h6, "os_csr_t6");
        rd_chk(4'hB, 32'd0, "os_cnt_t6");
        irq_chk(1'b0, "os_irq_masked");

        // Channel 1, LOAD=RELOAD=0: event every tick; clear vs event priority
        wr(4'h4, 32'h1);
        wait_ticks(1);
        rd_chk(4'h4, 32'h5, "clr_ev_set");
        wr(4'h4, 32'h5);
        rd_chk(4'h4, 32'h1, "clr_off_tick");
        do begin
            @(posedge clk); #1;
        end while (ecnt % PRESCALE != PRESCALE - 2);
        wr(4'h4, 32'h5);                 // commits on the tick edge
        rd_chk(4'h4, 32'h5, "clr_on_event");
        wait_ticks(1);
        wr(4'h4, 32'h4);
        rd_chk(4'h4, 32'h0, "clr_disable");

        // All channels together
        wr(4'h1, 32'd2);
        wr(4'h5, 32'd4);
        wr(4'h9, 32'd6);
        wait_ticks(1);
        wr(4'h0, 32'hD);
        wr(4'h4, 32'hF);
        wr(4'h8, 32'h7);
        wait_ticks(3);
        irq_chk(IRQ_EN, "m_irq_ch0");
        rd_chk(4'h0, 32'h15 | EVB, "m_csr0_t3");
        rd_chk(4'h4, 32'h13 | EVB, "m_csr1_t3");
        rd_chk(4'h7, 32'd1, "m_cnt1_t3");
        rd_chk(4'hB, 32'd3, "m_cnt2_t3");
        wr(4'h0, 32'hD);
        irq_chk(1'b0, "m_irq_ch0_clr");
        wait_ticks(2);
        irq_chk(IRQ_EN, "m_irq_ch1");
        rd_chk(4'h4, 32'h6 | EVB, "m_csr1_t5");
        rd_chk(4'h0, 32'h11 | EVB, "m_csr0_t5");
        rd_chk(4'hB, 32'd1, "m_cnt2_t5");
        wait_ticks(2);
        rd_chk(4'h8, 32'h6, "m_csr2_t7");
        check("m_irq_t7", {31'b0, irq}, {31'b0, IRQ_EN});
        wr(4'h4, 32'h4);
        irq_chk(1'b0, "m_irq_all_clr");
        rd_chk(4'hC, 32'h0, "oor_csr");
        rd_chk(4'hE, 32'h0, "oor_reload");

        // Reset in the middle of a count on channel 1
        wr(4'h5, 32'd20);
        wr(4'h4, 32'h9);
        wait_ticks(3);
        rd_chk(4'h7, 32'd17, "rst_cnt_before");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_irq", {31'b0, irq}, 32'h0);
        rd_chk(4'h7, 32'd0, "rst_cnt");
        rd_chk(4'h4, 32'h0, "rst_csr");
        rd_chk(4'h5, 32'h0, "rst_load");
        wait_ticks(3);
        rd_chk(4'h4, 32'h0, "rst_no_event");
        irq_chk(1'b0, "rst_irq_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
